pointer_rd: RTL
===============

Name: pointer_rd

Overview:
Read-side pointer and occupancy controller for the T08 FIFO, the counterpart of the write pointer. It accepts pop requests, generates the RAM read strobe, read address and read-data-valid, and tracks occupancy from the writer's write strobe. It also produces the empty_flag and full_flag consumed by both FIFO ends. It sits between the top-level pop input, the dual-port RAM read port and the write-pointer block.

Parameters:
DEPTH, W_DEPTH (fifo_pkg), number of FIFO slots; must be ≥2.
RD_LAT, 1, RAM read latency in cycles (1..3); sets the rd_valid delay.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
pop  input  1  read request, sampled each rising edge
ena_wr  input  1  write strobe from write pointer; each high cycle is one committed write
ena_rd  output  1  RAM read enable, registered
addr_rd  output  addr_t  RAM read address, valid while ena_rd=1
rd_valid  output  1  RAM data valid, ena_rd delayed RD_LAT cycles
empty_flag  output  1  occupancy = 0
full_flag  output  1  occupancy = DEPTH; drives the write pointer's full_flag
count  output  cnt_t  occupancy, 0..DEPTH
led_error  output  1  underflow indicator: pop while empty
err_ovf  output  1  sticky: ena_wr seen while full

Behaviour:
- One clock: clk. Reset is asynchronous, active-high, on rst.
- Reset values:
  - ena_rd=0, rd_valid=0 (whole pipe cleared), count=0, led_error=0, err_ovf=0.
  - tail_r=DEPTH-1, so the first read uses address 0, matching the writer.
  - State=ST_EMPTY, so empty_flag=1 and full_flag=0.
- Accepted pop: pop=1 and empty_flag=0 at an edge. At that edge:
  - tail_r <= (tail_r+1) mod DEPTH.
  - ena_rd <= 1.
  - addr_rd = tail_r combinationally, so the slot read is the one just advanced to.
  - Otherwise ena_rd <= 0 and tail_r holds.
- Underflow: pop=1 and empty_flag=1.
  - No pointer move, ena_rd <= 0, led_error <= 1.
  - led_error <= 0 on any other cycle (level per cycle, not sticky).
- rd_valid: shift register of length RD_LAT fed by ena_rd. Data is valid RD_LAT cycles after ena_rd.
- Occupancy: wr_ev = ena_wr; rd_ev = accepted pop.
  - wr_ev only: count+1.
  - rd_ev only: count-1.
  - Both, or neither: count holds.
  - wr_ev while count=DEPTH: count saturates at DEPTH and err_ovf <= 1, sticky until rst.
  - count never goes below 0.
- Flag FSM, states ST_EMPTY / ST_PART / ST_FULL, registered, updated from the next count:
  - ST_EMPTY→ST_PART on wr_ev without rd_ev.
  - ST_PART→ST_EMPTY when count=1 and rd_ev without wr_ev.
  - ST_PART→ST_FULL when count=DEPTH-1 and wr_ev without rd_ev.
  - ST_FULL→ST_PART on rd_ev without wr_ev.
  - Simultaneous wr_ev and rd_ev: state holds.
  - empty_flag = (state==ST_EMPTY); full_flag = (state==ST_FULL). Both are decoded from the state register (glitch-free) and must always match count.
- No write-to-read bypass:
  - A write committed in cycle N clears empty_flag at edge N+1.
  - The earliest read of that slot has ena_rd=1 in cycle N+2.
- Wrap-around: addr_rd goes DEPTH-1 → 0. count is independent of address wrap.
- Reset mid-operation: all state clears immediately, including any in-flight rd_valid. There is no post-reset completion of pending reads.

Decomposition:
- fifo_pkg holds W_DEPTH, addr_t, cnt_t (logic [$clog2(W_DEPTH+1)-1:0]) and the flag-state enum fstate_t {ST_EMPTY, ST_PART, ST_FULL}.
- One sub-module: fifo_occupancy. It holds the count, the flag FSM and err_ovf. pointer_rd instantiates it and keeps the tail pointer, ena_rd, the rd_valid pipe and led_error.

Test Plan (DEPTH=8, RD_LAT=1):
1. Reset, 4 ena_wr pulses, then 4 pops → count 0→4→0. ena_rd with addr_rd 0,1,2,3; rd_valid one cycle after each; empty_flag=1 at end.
2. Pop on empty after reset → ena_rd=0, addr_rd stays 7, led_error=1 for exactly one cycle, count=0.
3. 8 writes → full_flag=1, count=8. A 9th ena_wr → count stays 8, err_ovf=1 until rst. One pop → full_flag=0 next edge, count=7.
4. Simultaneous ena_wr and pop at count=3 for 10 cycles → count stays 3, state ST_PART. addr_rd wraps 7→0.
5. Single write in cycle N with pop held high from N → empty_flag low at N+1, ena_rd=1 at N+2 with addr 0, rd_valid at N+3.
6. rst asserted asynchronously mid-burst while rd_valid=1 → all outputs return to reset values before the next edge. The next read uses addr_rd 0.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkg
// Brief   : Shared FIFO sizing, pointer/count types and flag-state encoding.
// Revision: 1.0
// ============================================================================
package fifo_pkg;

  localparam int W_DEPTH = 8;
  localparam int ADDR_W  = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
  localparam int CNT_W   = $clog2(W_DEPTH + 1);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PART  = 2'd1,
    ST_FULL  = 2'd2
  } fstate_t;

  // Modulo-DEPTH increment; DEPTH need not be a power of two.
  function automatic addr_t next_addr(input addr_t a, input int depth);
    if (a == addr_t'(depth - 1)) begin
      return '0;
    end
    return a + addr_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pointer_rd_if.sv
`default_nettype none
// ============================================================================
// Module  : pointer_rd_if
// Brief   : Read-side FIFO control bundle between pop/write sources and pointer_rd.
// Revision: 1.0
// ============================================================================
interface pointer_rd_if;
  import fifo_pkg::*;

  logic  pop;
  logic  ena_wr;
  logic  ena_rd;
  addr_t addr_rd;
  logic  rd_valid;
  logic  empty_flag;
  logic  full_flag;
  cnt_t  count;
  logic  led_error;
  logic  err_ovf;

  modport master (
    output pop,
    output ena_wr,
    input  ena_rd,
    input  addr_rd,
    input  rd_valid,
    input  empty_flag,
    input  full_flag,
    input  count,
    input  led_error,
    input  err_ovf
  );

  modport slave (
    input  pop,
    input  ena_wr,
    output ena_rd,
    output addr_rd,
    output rd_valid,
    output empty_flag,
    output full_flag,
    output count,
    output led_error,
    output err_ovf
  );

endinterface
`default_nettype wire

// File: rtl/fifo_occupancy.sv
`default_nettype none
// ============================================================================
// Module  : fifo_occupancy
// Brief   : Occupancy counter, empty/part/full flag FSM and sticky overflow flag.
// Revision: 1.0
// ============================================================================
module fifo_occupancy
  import fifo_pkg::*;
#(
  parameter int DEPTH = W_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_ev,
  input  logic rd_ev,
  output cnt_t count,
  output logic empty_flag,
  output logic full_flag,
  output logic err_ovf
);

  localparam cnt_t C_FULL_CNT = cnt_t'(DEPTH);
  localparam cnt_t C_NEAR_CNT = cnt_t'(DEPTH - 1);
  localparam cnt_t C_ONE_CNT  = cnt_t'(1);

  cnt_t    count_r;
  cnt_t    count_nxt;
  fstate_t state_r;
  fstate_t state_nxt;
  logic    err_ovf_r;
  logic    w_wr_only;
  logic    w_rd_only;

  assign w_wr_only = wr_ev & ~rd_ev;
  assign w_rd_only = rd_ev & ~wr_ev;

  // Count saturates at both ends rather than wrapping.
  always_comb begin
    count_nxt = count_r;
    if (w_wr_only && (count_r != C_FULL_CNT)) begin
      count_nxt = count_r + C_ONE_CNT;
    end else if (w_rd_only && (count_r != '0)) begin
      count_nxt = count_r - C_ONE_CNT;
    end
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (w_wr_only) begin
          state_nxt = ST_PART;
        end
      end
      ST_PART: begin
        if (w_rd_only && (count_r == C_ONE_CNT)) begin
          state_nxt = ST_EMPTY;
        end else if (w_wr_only && (count_r == C_NEAR_CNT)) begin
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_rd_only) begin
          state_nxt = ST_PART;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= '0;
      state_r   <= ST_EMPTY;
      err_ovf_r <= 1'b0;
    end else begin
      count_r <= count_nxt;
      state_r <= state_nxt;
      if (wr_ev && (count_r == C_FULL_CNT)) begin
        err_ovf_r <= 1'b1;
      end
    end
  end

  assign count      = count_r;
  assign empty_flag = (state_r == ST_EMPTY);
  assign full_flag  = (state_r == ST_FULL);
  assign err_ovf    = err_ovf_r;

endmodule
`default_nettype wire

// File: rtl/pointer_rd.sv
`default_nettype none
// ============================================================================
// Module  : pointer_rd
// Brief   : FIFO read pointer: pop acceptance, RAM read strobe/address, data-valid pipe.
// Revision: 1.0
// ============================================================================
module pointer_rd
  import fifo_pkg::*;
#(
  parameter int DEPTH  = W_DEPTH,
  parameter int RD_LAT = 1
) (
  input logic         clk,
  input logic         rst,
  pointer_rd_if.slave bus
);

  addr_t             tail_r;
  logic              ena_rd_r;
  logic              led_error_r;
  logic [RD_LAT-1:0] vld_pipe_r;
  logic              w_empty;
  logic              w_full;
  logic              w_accept;
  cnt_t              w_count;
  logic              w_err_ovf;

  assign w_accept = bus.pop & ~w_empty;

  // tail_r resets to the last slot so the first accepted pop lands on slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_r      <= addr_t'(DEPTH - 1);
      ena_rd_r    <= 1'b0;
      led_error_r <= 1'b0;
    end else begin
      ena_rd_r    <= w_accept;
      led_error_r <= bus.pop & w_empty;
      if (w_accept) begin
        tail_r <= next_addr(tail_r, DEPTH);
      end
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat_one
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe_r <= '0;
        end else begin
          vld_pipe_r <= ena_rd_r;
        end
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe_r <= '0;
        end else begin
          vld_pipe_r <= {vld_pipe_r[RD_LAT-2:0], ena_rd_r};
        end
      end
    end
  endgenerate

  fifo_occupancy #(
    .DEPTH (DEPTH)
  ) u_occupancy (
    .clk        (clk),
    .rst        (rst),
    .wr_ev      (bus.ena_wr),
    .rd_ev      (w_accept),
    .count      (w_count),
    .empty_flag (w_empty),
    .full_flag  (w_full),
    .err_ovf    (w_err_ovf)
  );

  assign bus.ena_rd     = ena_rd_r;
  assign bus.addr_rd    = tail_r;
  assign bus.rd_valid   = vld_pipe_r[RD_LAT-1];
  assign bus.empty_flag = w_empty;
  assign bus.full_flag  = w_full;
  assign bus.count      = w_count;
  assign bus.led_error  = led_error_r;
  assign bus.err_ovf    = w_err_ovf;

endmodule
`default_nettype wire
